// File: rtl/dmem_pkg.sv
// Shared types and defaults for the two-port dmem arbiter.
// Holds the lock FSM encoding and helpers that map lock state to allowed ports.
package dmem_pkg;

    localparam int DMEM_DWIDTH   = 32;
    localparam int DMEM_AWIDTH   = 14;
    localparam int DMEM_LOCK_MAX = 16;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_e;

    // Ports permitted to win arbitration in a given lock state (bit n = port n).
    function automatic logic [1:0] allow_mask(input lock_state_e st);
        case (st)
            LOCKED0: allow_mask = 2'b01;
            LOCKED1: allow_mask = 2'b10;
            default: allow_mask = 2'b11;
        endcase
    endfunction

    function automatic lock_state_e locked_state(input port_idx_t n);
        locked_state = (n == PORT1) ? LOCKED1 : LOCKED0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the prio port wins when eligible, otherwise the other port.
// Purely combinational; the caller owns the priority pointer.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] valid,
    input  logic [1:0] allow,
    input  port_idx_t  prio,
    output logic [1:0] gnt,
    output port_idx_t  gnt_idx,
    output logic       gnt_any
);

    logic [1:0] cand;

    // NOTE: every output gets a default before the if-chain so no path leaves
    // a value unassigned; that is what keeps this block free of latches.
    always_comb begin
        cand    = valid & allow;
        gnt     = 2'b00;
        gnt_idx = prio;
        gnt_any = 1'b0;
        if (cand[prio]) begin
            gnt[prio] = 1'b1;
            gnt_idx   = prio;
            gnt_any   = 1'b1;
        end else if (cand[~prio]) begin
            gnt[~prio] = 1'b1;
            gnt_idx    = ~prio;
            gnt_any    = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port dmem between the CPU LSU (port 0) and the debug loader (port 1).
// Round-robin with burst locking bounded by LOCK_MAX; responses are registered one cycle after accept.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DWIDTH   = DMEM_DWIDTH,
    parameter int AWIDTH   = DMEM_AWIDTH,
    parameter int LOCK_MAX = DMEM_LOCK_MAX
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                p0_req_valid,
    output logic                p0_req_ready,
    input  logic [DWIDTH/8-1:0] p0_wbe,
    input  logic [AWIDTH-1:0]   p0_addr,
    input  logic [DWIDTH-1:0]   p0_wdata,
    input  logic                p0_lock,
    output logic                p0_resp_valid,
    output logic [DWIDTH-1:0]   p0_rdata,

    input  logic                p1_req_valid,
    output logic                p1_req_ready,
    input  logic [DWIDTH/8-1:0] p1_wbe,
    input  logic [AWIDTH-1:0]   p1_addr,
    input  logic [DWIDTH-1:0]   p1_wdata,
    input  logic                p1_lock,
    output logic                p1_resp_valid,
    output logic [DWIDTH-1:0]   p1_rdata,

    output logic [DWIDTH/8-1:0] mem_wbe,
    output logic [AWIDTH-1:0]   mem_addr,
    output logic [DWIDTH-1:0]   mem_dataw,
    input  logic [DWIDTH-1:0]   mem_datar
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    lock_state_e   state_q, state_d;
    port_idx_t     prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    gnt;
    logic [1:0]    acc;
    port_idx_t     gnt_idx;
    port_idx_t     sel;
    logic          gnt_any;
    logic          acc_any;
    logic          lock_sel;

    rr_arb2 u_rr_arb2 (
        .valid   ({p1_req_valid, p0_req_valid}),
        .allow   (allow_mask(state_q)),
        .prio    (prio_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Handshakes are masked while in reset so neither requester sees a false accept.
    assign acc          = gnt & {2{rst_n}};
    assign acc_any      = gnt_any & rst_n;
    assign p0_req_ready = acc[0];
    assign p1_req_ready = acc[1];

    // Port 0 drives the memory bus when idle; writes only happen on a real accept.
    assign sel       = gnt_any ? gnt_idx : PORT0;
    assign mem_addr  = (sel == PORT1) ? p1_addr  : p0_addr;
    assign mem_dataw = (sel == PORT1) ? p1_wdata : p0_wdata;
    assign mem_wbe   = acc_any ? ((sel == PORT1) ? p1_wbe : p0_wbe) : '0;
    assign lock_sel  = (sel == PORT1) ? p1_lock : p0_lock;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        if (acc_any) begin
            case (state_q)
                UNLOCKED: begin
                    prio_d = ~sel;
                    // With LOCK_MAX of one a single grant already exhausts the burst.
                    if (lock_sel && (LOCK_MAX > 1)) begin
                        state_d = locked_state(sel);
                        cnt_d   = CW'(1);
                    end
                end
                LOCKED0, LOCKED1: begin
                    if (!lock_sel || (cnt_q == CNT_LAST)) begin
                        state_d = UNLOCKED;
                        prio_d  = ~sel;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNLOCKED;
            prio_q  <= PORT0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // mem_datar is the pre-edge word, so a write response returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_resp_valid <= 1'b0;
            p1_resp_valid <= 1'b0;
            p0_rdata      <= '0;
            p1_rdata      <= '0;
        end else begin
            p0_resp_valid <= acc[0];
            p1_resp_valid <= acc[1];
            if (acc[0]) p0_rdata <= mem_datar;
            if (acc[1]) p1_rdata <= mem_datar;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem (async read, byte-enabled write).
// Accepted requests queue a hand-computed response; a monitor pops and compares each resp pulse.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int BW = DW / 8;

    logic          clk;
    logic          rst_n;
    logic          p0_req_valid, p0_req_ready, p0_lock, p0_resp_valid;
    logic [BW-1:0] p0_wbe;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req_valid, p1_req_ready, p1_lock, p1_resp_valid;
    logic [BW-1:0] p1_wbe;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [BW-1:0] mem_wbe;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dataw, mem_datar;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] exp0, exp1;
    int            checks = 0;
    int            errors = 0;

    dmem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .LOCK_MAX(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .p0_req_valid  (p0_req_valid),
        .p0_req_ready  (p0_req_ready),
        .p0_wbe        (p0_wbe),
        .p0_addr       (p0_addr),
        .p0_wdata      (p0_wdata),
        .p0_lock       (p0_lock),
        .p0_resp_valid (p0_resp_valid),
        .p0_rdata      (p0_rdata),
        .p1_req_valid  (p1_req_valid),
        .p1_req_ready  (p1_req_ready),
        .p1_wbe        (p1_wbe),
        .p1_addr       (p1_addr),
        .p1_wdata      (p1_wdata),
        .p1_lock       (p1_lock),
        .p1_resp_valid (p1_resp_valid),
        .p1_rdata      (p1_rdata),
        .mem_wbe       (mem_wbe),
        .mem_addr      (mem_addr),
        .mem_dataw     (mem_dataw),
        .mem_datar     (mem_datar)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_datar = mem[mem_addr];

    always @(posedge clk) begin
        for (int b = 0; b < BW; b++)
            if (mem_wbe[b]) mem[mem_addr][8*b +: 8] <= mem_dataw[8*b +: 8];
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endfunction

    // Issue side: every accept queues the response the bench expects for it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0_req_valid && p0_req_ready) exp_q.push_back('{port: 1'b0, data: exp0});
            if (p1_req_valid && p1_req_ready) exp_q.push_back('{port: 1'b1, data: exp1});
        end
    end

    // Monitor side: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (p0_resp_valid) begin
                if (exp_q.size() == 0) check("p0 unexpected resp", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("p0 resp port", 64'd0, 64'(e.port));
                    check("p0 rdata", 64'(p0_rdata), 64'(e.data));
                end
            end
            if (p1_resp_valid) begin
                if (exp_q.size() == 0) check("p1 unexpected resp", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("p1 resp port", 64'd1, 64'(e.port));
                    check("p1 rdata", 64'(p1_rdata), 64'(e.data));
                end
            end
        end
    end

    task automatic drive(input int p, input logic v, input logic [BW-1:0] wbe, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic lk, input logic [DW-1:0] ex);
        if (p == 0) begin
            p0_req_valid = v; p0_wbe = wbe; p0_addr = a; p0_wdata = wd; p0_lock = lk; exp0 = ex;
        end else begin
            p1_req_valid = v; p1_wbe = wbe; p1_addr = a; p1_wdata = wd; p1_lock = lk; exp1 = ex;
        end
    endtask

    task automatic idle(input int p);
        drive(p, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string name, input logic r0, input logic r1);
        @(negedge clk);
        check({name, " p0_ready"}, 64'(p0_req_ready), 64'(r0));
        check({name, " p1_ready"}, 64'(p1_req_ready), 64'(r1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        rst_n = 1'b0;
        drive(0, 1'b1, 4'hf, 14'd5, 32'h11111111, 1'b1, '0);
        drive(1, 1'b1, 4'hf, 14'd6, 32'h22222222, 1'b1, '0);

        // Reset: nothing is granted and nothing is written.
        chk_ready("reset", 1'b0, 1'b0);
        check("reset mem_wbe", 64'(mem_wbe), 64'd0);
        tick();
        idle(0); idle(1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post-reset p0_resp_valid", 64'(p0_resp_valid), 64'd0);
        check("post-reset p1_resp_valid", 64'(p1_resp_valid), 64'd0);
        tick();

        // p0 writes, p1 reads it back.
        drive(0, 1'b1, 4'hf, 14'd0, 32'hdeadbeef, 1'b0, 32'h0);
        chk_ready("wr0", 1'b1, 1'b0);
        check("wr0 mem_wbe", 64'(mem_wbe), 64'hf);
        tick();
        idle(0);
        drive(1, 1'b1, 4'h0, 14'd0, '0, 1'b0, 32'hdeadbeef);
        chk_ready("rd1", 1'b0, 1'b1);
        tick();
        idle(1);
        tick();

        // Contention without lock alternates grants.
        drive(0, 1'b1, 4'h0, 14'd0, '0, 1'b0, 32'hdeadbeef);
        drive(1, 1'b1, 4'h0, 14'd1, '0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk_ready($sformatf("alt%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
        end
        idle(0); idle(1);
        tick();

        // Point prio at p1, then a p1 locked burst must starve p0 until released.
        drive(0, 1'b1, 4'h0, 14'd2, '0, 1'b0, 32'h0);
        chk_ready("prio-set", 1'b1, 1'b0);
        tick();
        drive(0, 1'b1, 4'h0, 14'd0, '0, 1'b0, 32'hdeadbeef);
        drive(1, 1'b1, 4'h1, 14'd1, 32'h123456be, 1'b1, 32'h0);
        chk_ready("burst0", 1'b0, 1'b1);
        tick();
        drive(1, 1'b1, 4'h1, 14'd2, 32'h123456be, 1'b1, 32'h0);
        chk_ready("burst1", 1'b0, 1'b1);
        tick();
        drive(1, 1'b1, 4'h1, 14'd3, 32'h123456be, 1'b0, 32'h0);
        chk_ready("burst2", 1'b0, 1'b1);
        tick();
        idle(1);
        chk_ready("after-burst", 1'b1, 1'b0);
        tick();
        idle(0);
        tick();

        // Forced unlock after LOCK_MAX=4 locked grants to p0.
        drive(0, 1'b1, 4'h0, 14'd0, '0, 1'b1, 32'hdeadbeef);
        chk_ready("starve1", 1'b1, 1'b0);
        tick();
        drive(1, 1'b1, 4'h0, 14'd3, '0, 1'b0, 32'h000000be);
        for (int k = 2; k <= 4; k++) begin
            chk_ready($sformatf("starve%0d", k), 1'b1, 1'b0);
            tick();
        end
        chk_ready("forced-unlock", 1'b0, 1'b1);
        tick();
        idle(0); idle(1);
        tick();

        // Read-during-write returns the old word; partial write merges bytes.
        drive(0, 1'b1, 4'h3, 14'd1, 32'hffffffff, 1'b0, 32'h000000be);
        chk_ready("rdw", 1'b1, 1'b0);
        tick();
        drive(0, 1'b1, 4'h0, 14'd1, '0, 1'b0, 32'h0000ffff);
        @(negedge clk);
        check("mem[1] after partial write", 64'(mem[1]), 64'h0000ffff);
        tick();
        idle(0);
        tick();

        // Reset in the middle of a p1 lock drops the lock and the pending pulse.
        drive(1, 1'b1, 4'h0, 14'd2, '0, 1'b1, 32'h000000be);
        chk_ready("pre-reset lock", 1'b0, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset clears p1_resp_valid", 64'(p1_resp_valid), 64'd0);
        drive(0, 1'b1, 4'h0, 14'd0, '0, 1'b0, 32'hdeadbeef);
        drive(1, 1'b1, 4'h0, 14'd1, '0, 1'b0, 32'h0000ffff);
        @(posedge clk); #1 rst_n = 1'b1;
        chk_ready("post-reset contention", 1'b1, 1'b0);
        tick();
        idle(0);
        chk_ready("post-reset p1 next", 1'b0, 1'b1);
        tick();
        idle(1);
        tick();
        tick();

        check("outstanding responses", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
